// File: rtl/chess_pkg.sv
// chess_pkg: shared chess definitions for the pawn move generator.
//   - piece_t   : one signed board byte (white > 0, black < 0, EMPTY = 0)
//   - board_t   : 64 bytes, square s = row*8 + col, row 0 = white back rank
//   - piece code ranges, MAX_PAWN_MOVES, FSM state encoding
//   - helpers classifying a piece relative to the side to move
package chess_pkg;

  typedef logic signed [7:0] piece_t;
  typedef logic [63:0][7:0]  board_t;

  localparam piece_t EMPTY   = 8'sd0;
  localparam piece_t W_PAWN0 = 8'sd1;
  localparam piece_t W_PAWN7 = 8'sd8;
  localparam piece_t W_ROOK0 = 8'sd9;
  localparam piece_t W_KNIGHT0 = 8'sd19;
  localparam piece_t W_BISHOP0 = 8'sd29;
  localparam piece_t W_QUEEN0  = 8'sd39;
  localparam piece_t W_KING    = 8'sd48;
  localparam piece_t B_PAWN0 = -8'sd1;
  localparam piece_t B_PAWN7 = -8'sd8;
  localparam piece_t B_ROOK0 = -8'sd9;
  localparam piece_t B_KNIGHT0 = -8'sd19;
  localparam piece_t B_BISHOP0 = -8'sd29;
  localparam piece_t B_QUEEN0  = -8'sd39;
  localparam piece_t B_KING    = -8'sd48;

  // Promoted queen code = pawn code +/- this offset (3 -> 42, -3 -> -42).
  localparam piece_t QUEEN_OFFSET = 8'sd39;

  localparam int MAX_PAWN_MOVES = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // side: 0 = white, 1 = black
  function automatic logic is_own_pawn(input piece_t p, input logic side);
    return side ? ((p <= B_PAWN0) && (p >= B_PAWN7))
                : ((p >= W_PAWN0) && (p <= W_PAWN7));
  endfunction

  function automatic logic is_enemy(input piece_t p, input logic side);
    return side ? (p > EMPTY) : (p < EMPTY);
  endfunction

endpackage

// File: rtl/pawn_move_rules.sv
// pawn_move_rules: combinational pawn move candidates for one square.
// Ports:
//   i_board : full board
//   i_sq    : square under examination
//   i_side  : side to move (0 white, 1 black)
//   o_dst   : candidate destinations [0]=push [1]=double [2]=cap left [3]=cap right
//   o_valid : per-candidate legality (all 0 if i_sq is not an own pawn)
//   o_promo : destination lies on the last row (queen replaces the pawn)
module pawn_move_rules
  import chess_pkg::*;
(
  input  board_t          i_board,
  input  logic [5:0]      i_sq,
  input  logic            i_side,
  output logic [3:0][5:0] o_dst,
  output logic [3:0]      o_valid,
  output logic            o_promo
);

  logic [2:0] w_row;
  logic [2:0] w_col;
  piece_t     w_piece;
  logic       w_own;
  logic       w_can_fwd;
  logic       w_start;
  logic [5:0] w_fwd;
  logic [5:0] w_fwd2;
  logic [5:0] w_left;
  logic [5:0] w_right;
  piece_t     w_f1;
  piece_t     w_f2;
  piece_t     w_cl;
  piece_t     w_cr;

  assign w_row   = i_sq[5:3];
  assign w_col   = i_sq[2:0];
  assign w_piece = piece_t'(i_board[i_sq]);
  assign w_own   = is_own_pawn(w_piece, i_side);

  // A pawn on its far edge row has no forward square; the index arithmetic
  // below may wrap there, but every move is gated by w_can_fwd.
  assign w_can_fwd = i_side ? (w_row != 3'd0) : (w_row != 3'd7);
  assign w_start   = i_side ? (w_row == 3'd6) : (w_row == 3'd1);
  assign w_fwd     = i_side ? (i_sq - 6'd8)  : (i_sq + 6'd8);
  assign w_fwd2    = i_side ? (i_sq - 6'd16) : (i_sq + 6'd16);
  assign w_left    = w_fwd - 6'd1;
  assign w_right   = w_fwd + 6'd1;

  assign w_f1 = piece_t'(i_board[w_fwd]);
  assign w_f2 = piece_t'(i_board[w_fwd2]);
  assign w_cl = piece_t'(i_board[w_left]);
  assign w_cr = piece_t'(i_board[w_right]);

  assign o_dst[0] = w_fwd;
  assign o_dst[1] = w_fwd2;
  assign o_dst[2] = w_left;
  assign o_dst[3] = w_right;

  // Column guards stop diagonal captures wrapping between the a and h files.
  assign o_valid[0] = w_own && w_can_fwd && (w_f1 == EMPTY);
  assign o_valid[1] = w_own && w_start && (w_f1 == EMPTY) && (w_f2 == EMPTY);
  assign o_valid[2] = w_own && w_can_fwd && (w_col != 3'd0) && is_enemy(w_cl, i_side);
  assign o_valid[3] = w_own && w_can_fwd && (w_col != 3'd7) && is_enemy(w_cr, i_side);

  // Every move of a given pawn lands on the same row, so one flag suffices.
  assign o_promo = i_side ? (w_row == 3'd1) : (w_row == 3'd6);

endmodule

// File: rtl/pawn.sv
// pawn: Avalon-MM pawn move generator.
// Reads a 64-byte board from src, scans squares 0..63 for own pawns and
// writes one full result board per legal move to dst + n*64 (at most
// MAX_PAWN_MOVES boards). A host read stalls until generation is done.
// Ports:
//   clk, rst_n                : clock, asynchronous active-high reset
//   slave_*                   : register interface (0 src, 1 dst+start, 2 side;
//                               any read returns the move count)
//   master_*                  : byte-per-transaction memory master
// Handshakes: a master request (read/write + address + data) is held stable
// while master_waitrequest is 1 and completes on the first cycle it is 0;
// read data is taken on master_readdatavalid, one read outstanding at a time.
module pawn
  import chess_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam logic [3:0] LAST_MOVE = 4'(MAX_PAWN_MOVES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_src_base;
  logic [31:0] r_dst_base;
  logic        r_side;
  logic [3:0]  r_count;
  board_t      r_board;
  logic [5:0]  r_idx;
  logic        r_rd_wait;
  logic [5:0]  r_sq;
  logic [1:0]  r_cand;
  logic [5:0]  r_mv_src;
  logic [5:0]  r_mv_dst;
  piece_t      r_mv_piece;

  logic [3:0][5:0] w_dst;
  logic [3:0]      w_valid;
  logic            w_promo;
  logic            w_cand_valid;
  logic            w_last_cand;
  logic            w_cfg_write;
  logic            w_rd_data;
  logic            w_wr_accept;
  piece_t          w_pawn;
  piece_t          w_queen;
  logic [7:0]      w_out_byte;
  logic            w_unused;

  pawn_move_rules u_rules (
    .i_board (r_board),
    .i_sq    (r_sq),
    .i_side  (r_side),
    .o_dst   (w_dst),
    .o_valid (w_valid),
    .o_promo (w_promo)
  );

  assign w_cand_valid = w_valid[r_cand];
  assign w_last_cand  = (r_sq == 6'd63) && (r_cand == 2'd3);
  assign w_cfg_write  = slave_write && (r_state == ST_IDLE);
  assign w_rd_data    = (r_state == ST_READ) && r_rd_wait && master_readdatavalid;
  assign w_wr_accept  = (r_state == ST_WRITE) && !master_waitrequest;
  assign w_pawn       = piece_t'(r_board[r_sq]);
  assign w_queen      = r_side ? (w_pawn - QUEEN_OFFSET) : (w_pawn + QUEEN_OFFSET);
  assign w_unused     = ^master_readdata[31:8];

  // Result board byte: source emptied, destination holds the moving piece.
  assign w_out_byte = (r_idx == r_mv_src) ? 8'd0 :
                      (r_idx == r_mv_dst) ? r_mv_piece : r_board[r_idx];

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cfg_write && (slave_address == 4'd1)) w_next = ST_READ;
      ST_READ:  if (w_rd_data && (r_idx == 6'd63)) w_next = ST_SCAN;
      ST_SCAN: begin
        if (w_cand_valid)     w_next = ST_WRITE;
        else if (w_last_cand) w_next = ST_DONE;
      end
      ST_WRITE: begin
        if (w_wr_accept && (r_idx == 6'd63)) begin
          if ((r_count == LAST_MOVE) || w_last_cand) w_next = ST_DONE;
          else                                       w_next = ST_SCAN;
        end
      end
      ST_DONE:  if (slave_read) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    master_read       = 1'b0;
    master_write      = 1'b0;
    master_address    = 32'd0;
    master_writedata  = 32'd0;
    slave_waitrequest = 1'b0;
    slave_readdata    = {28'd0, r_count};
    case (r_state)
      ST_READ: begin
        master_read    = !r_rd_wait;
        master_address = r_rd_wait ? 32'd0 : (r_src_base + {26'd0, r_idx});
        slave_waitrequest = slave_read;
      end
      ST_SCAN: slave_waitrequest = slave_read;
      ST_WRITE: begin
        master_write     = 1'b1;
        master_address   = r_dst_base + {22'd0, r_count, 6'd0} + {26'd0, r_idx};
        master_writedata = {24'd0, w_out_byte};
        slave_waitrequest = slave_read;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_src_base <= 32'd0;
      r_dst_base <= 32'd0;
      r_side     <= 1'b0;
      r_count    <= 4'd0;
      r_board    <= '0;
      r_idx      <= 6'd0;
      r_rd_wait  <= 1'b0;
      r_sq       <= 6'd0;
      r_cand     <= 2'd0;
      r_mv_src   <= 6'd0;
      r_mv_dst   <= 6'd0;
      r_mv_piece <= EMPTY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_write) begin
            case (slave_address)
              4'd0: r_src_base <= slave_writedata;
              4'd1: begin
                r_dst_base <= slave_writedata;
                r_count    <= 4'd0;
                r_idx      <= 6'd0;
                r_rd_wait  <= 1'b0;
                r_sq       <= 6'd0;
                r_cand     <= 2'd0;
              end
              4'd2: r_side <= slave_writedata[0];
              default: ;
            endcase
          end
        end
        ST_READ: begin
          if (!r_rd_wait && !master_waitrequest) r_rd_wait <= 1'b1;
          if (w_rd_data) begin
            r_board[r_idx] <= master_readdata[7:0];
            r_rd_wait      <= 1'b0;
            r_idx          <= r_idx + 6'd1;
          end
        end
        ST_SCAN: begin
          if (w_cand_valid) begin
            r_mv_src   <= r_sq;
            r_mv_dst   <= w_dst[r_cand];
            r_mv_piece <= w_promo ? w_queen : w_pawn;
            r_idx      <= 6'd0;
          end else begin
            // Walk (square, candidate) pairs in emission order.
            {r_sq, r_cand} <= {r_sq, r_cand} + 8'd1;
          end
        end
        ST_WRITE: begin
          if (w_wr_accept) begin
            r_idx <= r_idx + 6'd1;
            if (r_idx == 6'd63) begin
              r_count        <= r_count + 4'd1;
              {r_sq, r_cand} <= {r_sq, r_cand} + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pawn.sv
module tb_pawn;

  localparam int SRC    = 0;
  localparam int DST    = 256;
  localparam int BUDGET = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  pawn dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  // clock
  always #5 clk = ~clk;

  // memory model and scoreboard state
  logic [7:0]  mem [0:2047];
  logic [7:0]  src_img [64];
  logic [7:0]  saved [0:767];
  logic [7:0]  exp_q [$];
  logic        rand_wait = 1'b0;
  logic        rd_pending = 1'b0;
  logic [10:0] rd_addr = '0;
  int          wr_cnt = 0;
  int          bad_upper = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory slave: decides waitrequest on the falling edge and commits the
  // transaction the DUT will see accepted on the next rising edge.
  initial begin
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = 32'd0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      master_readdata      = 32'd0;
      if (rd_pending) begin
        master_readdatavalid = 1'b1;
        master_readdata      = {24'hABCDEF, mem[rd_addr]};
        rd_pending           = 1'b0;
      end
      master_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (!rst_n && !master_waitrequest) begin
        if (master_read) begin
          rd_pending = 1'b1;
          rd_addr    = master_address[10:0];
        end
        if (master_write) begin
          mem[master_address[10:0]] = master_writedata[7:0];
          wr_cnt++;
          if (master_writedata[31:8] != 24'd0) bad_upper++;
        end
      end
    end
  end

  // driver tasks
  task automatic slv_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    slave_write = 1'b1; slave_address = addr; slave_writedata = data;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic slv_read(output logic [31:0] data, output int waited);
    @(negedge clk);
    slave_read = 1'b1; slave_address = 4'd0; waited = 0;
    #1;
    while (slave_waitrequest && waited < BUDGET) begin
      @(negedge clk); #1;
      waited++;
    end
    check_eq("rd_timeout", 32'(slave_waitrequest), 32'd0);
    data = slave_readdata;
    @(negedge clk);
    slave_read = 1'b0;
  endtask

  task automatic clear_img();
    for (int s = 0; s < 64; s++) src_img[s] = 8'd0;
  endtask

  task automatic std_img();
    logic [7:0] back [8];
    back = '{8'd9, 8'd19, 8'd29, 8'd39, 8'd48, 8'd30, 8'd20, 8'd10};
    clear_img();
    for (int c = 0; c < 8; c++) begin
      src_img[c]      = back[c];
      src_img[8 + c]  = 8'(c + 1);
      src_img[48 + c] = ~(8'(c + 1)) + 8'd1;
      src_img[56 + c] = ~back[c] + 8'd1;
    end
  endtask

  task automatic load_src();
    for (int s = 0; s < 64; s++) mem[SRC + s] = src_img[s];
    for (int a = DST; a < DST + 13 * 64; a++) mem[a] = 8'hAA;
    wr_cnt = 0; bad_upper = 0;
  endtask

  task automatic start_gen(input logic side);
    slv_write(4'd2, {31'd0, side});
    slv_write(4'd0, SRC);
    slv_write(4'd1, DST);
  endtask

  task automatic run_gen(input logic side, output logic [31:0] cnt, output int waited);
    start_gen(side);
    slv_read(cnt, waited);
  endtask

  task automatic check_board(input int n, input int src_sq, input int dst_sq, input logic [7:0] piece);
    logic [7:0] e;
    for (int s = 0; s < 64; s++)
      exp_q.push_back((s == src_sq) ? 8'd0 : (s == dst_sq) ? piece : src_img[s]);
    for (int s = 0; s < 64; s++) begin
      e = exp_q.pop_front();
      check_eq($sformatf("b%0d_s%0d", n, s), 32'(mem[DST + n * 64 + s]), 32'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_swait"}, 32'(slave_waitrequest), 32'd0);
    check_eq({tag, "_sdata"}, slave_readdata, 32'd0);
    check_eq({tag, "_mrd"},   32'(master_read), 32'd0);
    check_eq({tag, "_mwr"},   32'(master_write), 32'd0);
    check_eq({tag, "_maddr"}, master_address, 32'd0);
    check_eq({tag, "_mwdata"}, master_writedata, 32'd0);
  endtask

  logic [31:0] cnt;
  int          waited;
  int          mism;
  logic        saw_write;

  initial begin
    slave_address = 4'd0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = 32'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'd0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b0;

    // Standard opening, white: 16 moves truncated to 12; busy write ignored.
    std_img(); load_src();
    start_gen(1'b0);
    slv_write(4'd0, 32'h700);
    slv_read(cnt, waited);
    check_eq("std_count", cnt, 32'd12);
    check_eq("std_busy_stall", 32'(waited > 64), 32'd1);
    check_eq("std_writes", wr_cnt, 32'd768);
    check_eq("std_wdata_upper", bad_upper, 32'd0);
    check_eq("std_no_board12", 32'(mem[DST + 12 * 64]), 32'hAA);
    check_board(0, 8, 16, 8'd1);
    check_board(1, 8, 24, 8'd1);
    check_board(11, 13, 29, 8'd6);
    for (int a = 0; a < 768; a++) saved[a] = mem[DST + a];
    slv_read(cnt, waited);
    check_eq("idle_read_count", cnt, 32'd12);
    check_eq("idle_read_nowait", waited, 32'd0);

    // Black pawn with a push, double push and left capture of a rook.
    clear_img(); src_img[52] = -8'sd5; src_img[43] = 8'd9; load_src();
    run_gen(1'b1, cnt, waited);
    check_eq("blk_count", cnt, 32'd3);
    check_board(0, 52, 44, -8'sd5);
    check_board(1, 52, 36, -8'sd5);
    check_board(2, 52, 43, -8'sd5);

    // a-file pawn: enemy on s15 must not be captured across the edge.
    clear_img(); src_img[8] = 8'd1; src_img[15] = -8'sd9; src_img[17] = -8'sd9; load_src();
    run_gen(1'b0, cnt, waited);
    check_eq("afile_count", cnt, 32'd3);
    check_eq("afile_writes", wr_cnt, 32'd192);
    check_board(2, 8, 17, 8'd1);

    // White promotion.
    clear_img(); src_img[49] = 8'd2; load_src();
    run_gen(1'b0, cnt, waited);
    check_eq("wpromo_count", cnt, 32'd1);
    check_board(0, 49, 57, 8'd41);

    // Black promotion.
    clear_img(); src_img[9] = -8'sd3; load_src();
    run_gen(1'b1, cnt, waited);
    check_eq("bpromo_count", cnt, 32'd1);
    check_board(0, 9, 1, -8'sd42);

    // Blocked pawn: nothing generated, nothing written.
    clear_img(); src_img[20] = 8'd1; src_img[28] = 8'd9; load_src();
    run_gen(1'b0, cnt, waited);
    check_eq("blocked_count", cnt, 32'd0);
    check_eq("blocked_writes", wr_cnt, 32'd0);

    // Random waitrequest must give the same image as the zero-wait run.
    rand_wait = 1'b1;
    std_img(); load_src();
    run_gen(1'b0, cnt, waited);
    rand_wait = 1'b0;
    check_eq("wait_count", cnt, 32'd12);
    check_eq("wait_writes", wr_cnt, 32'd768);
    mism = 0;
    for (int a = 0; a < 768; a++) if (mem[DST + a] !== saved[a]) mism++;
    check_eq("wait_image", mism, 32'd0);

    // Reset in the middle of the write phase, then a clean rerun.
    std_img(); load_src();
    start_gen(1'b0);
    saw_write = 1'b0;
    for (int k = 0; k < BUDGET && !saw_write; k++) begin
      @(negedge clk); #1;
      if (master_write) saw_write = 1'b1;
    end
    check_eq("mid_saw_write", 32'(saw_write), 32'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b0;
    clear_img(); src_img[52] = -8'sd5; src_img[43] = 8'd9; load_src();
    run_gen(1'b1, cnt, waited);
    check_eq("post_rst_count", cnt, 32'd3);
    check_board(2, 52, 43, -8'sd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
